// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and a single-port data memory (slave).
// The master holds a request until the memory answers with a one-cycle ready.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: turns the ALU result into a load/store address or a
// pass-through writeback value, runs one outstanding data-memory access at a time,
// formats load/store data and presents a registered result to write-back.
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  output logic        mem_stall,
  mem_stage_if.master dmem,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic [31:0] wb_data,
  output logic        mem_fault,
  output logic [1:0]  fault_cause
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam bit         TO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic        regw_q;
  logic [7:0]  wait_cnt;

  logic        is_mem, illegal, misaligned, accept_access, timeout_hit;
  logic [31:0] st_wdata, ld_data;
  logic [3:0]  st_wstrb;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign mem_stall = (state == BUSY);

  // Decode the incoming EX instruction and format load data from the latched access.
  always_comb begin
    is_mem     = ex_mem_read | ex_mem_write;
    illegal    = (ex_mem_read && ex_mem_write)
              || (ex_mem_read && (ex_funct3 == 3'b011 || ex_funct3[2:1] == 2'b11))
              || (ex_mem_write && ex_funct3 >= 3'b011);
    misaligned = (ex_funct3[1:0] == 2'b01 && ex_alu_result[0])
              || (ex_funct3[1:0] == 2'b10 && ex_alu_result[1:0] != 2'b00);
    accept_access = ex_valid && is_mem && !illegal && !misaligned;

    st_wdata = ex_store_data;
    st_wstrb = 4'b1111;
    case (ex_funct3[1:0])
      2'b00: begin
        st_wdata = {4{ex_store_data[7:0]}};
        st_wstrb = 4'b0001 << ex_alu_result[1:0];
      end
      2'b01: begin
        st_wdata = {2{ex_store_data[15:0]}};
        st_wstrb = ex_alu_result[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase

    case (off_q)
      2'b00:   byte_lane = dmem.dmem_rdata[7:0];
      2'b01:   byte_lane = dmem.dmem_rdata[15:8];
      2'b10:   byte_lane = dmem.dmem_rdata[23:16];
      default: byte_lane = dmem.dmem_rdata[31:24];
    endcase
    half_lane = off_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];

    case (f3_q)
      3'b000:  ld_data = {{24{byte_lane[7]}}, byte_lane};
      3'b100:  ld_data = {24'd0, byte_lane};
      3'b001:  ld_data = {{16{half_lane[15]}}, half_lane};
      3'b101:  ld_data = {16'd0, half_lane};
      default: ld_data = dmem.dmem_rdata;
    endcase

    timeout_hit = TO_EN && !dmem.dmem_ready && (wait_cnt == TO_LAST);
  end

  // Next-state logic: enter BUSY on a legal access, leave on ready or timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_access) state_next = BUSY;
      BUSY:    if (dmem.dmem_ready || timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Bus request, access context and registered write-back results.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
      dmem.dmem_wstrb <= '0;
      off_q           <= '0;
      f3_q            <= '0;
      rd_q            <= '0;
      regw_q          <= 1'b0;
      wait_cnt        <= '0;
      wb_valid        <= 1'b0;
      wb_rd           <= '0;
      wb_reg_write    <= 1'b0;
      wb_data         <= '0;
      mem_fault       <= 1'b0;
      fault_cause     <= '0;
    end else begin
      wb_valid  <= 1'b0;
      mem_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid && !is_mem) begin
            wb_valid     <= 1'b1;
            wb_data      <= ex_alu_result;
            wb_rd        <= ex_rd;
            wb_reg_write <= ex_reg_write;
          end else if (ex_valid && (illegal || misaligned)) begin
            wb_valid     <= 1'b1;
            wb_data      <= '0;
            wb_rd        <= ex_rd;
            wb_reg_write <= 1'b0;
            mem_fault    <= 1'b1;
            fault_cause  <= illegal ? 2'b10 : 2'b01;
          end else if (accept_access) begin
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= ex_mem_write;
            dmem.dmem_addr  <= {ex_alu_result[31:2], 2'b00};
            dmem.dmem_wdata <= st_wdata;
            dmem.dmem_wstrb <= ex_mem_write ? st_wstrb : 4'b0000;
            off_q           <= ex_alu_result[1:0];
            f3_q            <= ex_funct3;
            rd_q            <= ex_rd;
            regw_q          <= ex_reg_write;
            wait_cnt        <= '0;
          end
        end
        BUSY: begin
          if (dmem.dmem_ready) begin
            dmem.dmem_req <= 1'b0;
            wb_valid      <= 1'b1;
            wb_rd         <= rd_q;
            wb_reg_write  <= dmem.dmem_we ? 1'b0 : regw_q;
            wb_data       <= dmem.dmem_we ? 32'd0 : ld_data;
          end else if (timeout_hit) begin
            dmem.dmem_req <= 1'b0;
            wb_valid      <= 1'b1;
            wb_rd         <= rd_q;
            wb_reg_write  <= 1'b0;
            wb_data       <= '0;
            mem_fault     <= 1'b1;
            fault_cause   <= 2'b11;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed instructions, a behavioural model of
// the expected retirements and bus activity, and one per-cycle compare process.
module tb_mem_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
  logic [31:0] ex_alu_result, ex_store_data;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        mem_stall, wb_valid, wb_reg_write, mem_fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  fault_cause;

  mem_stage_if bus();

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .mem_stall(mem_stall), .dmem(bus),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .mem_fault(mem_fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic access; logic fault; logic [1:0] cause; logic we;
    logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;
    logic [31:0] data; logic regw;
  } mres_t;

  typedef struct {
    int cyc; logic [31:0] data; logic regw; logic fault;
    logic [1:0] cause; logic chk_rd; logic [4:0] rd;
  } ret_t;

  ret_t        expq[$];
  int          total = 0, bad = 0, cyc = 0;
  int          busy_lo = 1, busy_hi = 0;
  bit          chk_en = 1'b0;
  logic        exp_we;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_wstrb;

  // Bench cycle counter, advanced on every rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural result of one instruction, computed from sizes, offsets and arithmetic.
  function automatic mres_t modelEval(input logic rd_, input logic wr_, input logic [2:0] f3,
                                      input logic [31:0] a, input logic [31:0] sd,
                                      input logic regw, input logic [31:0] rdata);
    mres_t r; int size; int off; int v; logic [31:0] lane; logic [31:0] mask;
    r = '{default: '0};
    off = int'(a[1:0]);
    if (!rd_ && !wr_) begin
      r.data = a; r.regw = regw;
      return r;
    end
    if ((rd_ && wr_) || (rd_ && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) || (wr_ && f3 > 3'd2)) begin
      r.fault = 1'b1; r.cause = 2'b10;
      return r;
    end
    size = 1 << f3[1:0];
    if ((int'(a[3:0]) % size) != 0) begin
      r.fault = 1'b1; r.cause = 2'b01;
      return r;
    end
    r.access = 1'b1;
    r.we     = wr_;
    r.addr   = a - 32'(off);
    if (wr_) begin
      case (size)
        1:       r.wdata = 32'(sd[7:0]) * 32'h0101_0101;
        2:       r.wdata = 32'(sd[15:0]) * 32'h0001_0001;
        default: r.wdata = sd;
      endcase
      r.wstrb = 4'(((1 << size) - 1) << off);
    end else begin
      lane = rdata >> (8 * off);
      if (size == 4) r.data = lane;
      else begin
        mask = 32'((1 << (8 * size)) - 1);
        v = int'(lane & mask);
        if (!f3[2] && v >= (1 << (8 * size - 1))) v -= (1 << (8 * size));
        r.data = 32'(v);
      end
      r.regw = regw;
    end
    return r;
  endfunction

  // Per-cycle comparison of bus activity and write-back against the model.
  always @(negedge clk) begin
    bit busy_exp;
    if (chk_en) begin
      busy_exp = (cyc >= busy_lo) && (cyc <= busy_hi);
      checkOutput("mem_stall", 32'(mem_stall), 32'(busy_exp));
      checkOutput("dmem_req", 32'(bus.dmem_req), 32'(busy_exp));
      if (busy_exp) begin
        checkOutput("dmem_addr", bus.dmem_addr, exp_addr);
        checkOutput("dmem_we", 32'(bus.dmem_we), 32'(exp_we));
        checkOutput("dmem_wstrb", 32'(bus.dmem_wstrb), 32'(exp_wstrb));
        if (exp_we) checkOutput("dmem_wdata", bus.dmem_wdata, exp_wdata);
      end
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
        checkOutput("wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("wb_data", wb_data, expq[0].data);
        checkOutput("wb_reg_write", 32'(wb_reg_write), 32'(expq[0].regw));
        checkOutput("mem_fault", 32'(mem_fault), 32'(expq[0].fault));
        if (expq[0].fault) checkOutput("fault_cause", 32'(fault_cause), 32'(expq[0].cause));
        if (expq[0].chk_rd) checkOutput("wb_rd", 32'(wb_rd), 32'(expq[0].rd));
        void'(expq.pop_front());
      end else begin
        checkOutput("wb_valid_idle", 32'(wb_valid), 32'd0);
        checkOutput("mem_fault_idle", 32'(mem_fault), 32'd0);
      end
    end
  end

  // Issue one instruction, play the memory side, and record the model's expectations.
  task automatic applyStimulus(input logic rd_, input logic wr_, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                               input logic regw, input int lat, input logic [31:0] rdata,
                               input int rst_at, input logic b2b);
    mres_t m; ret_t e; int k; int nbusy; bit timed_out; bit reset_hit;
    k = cyc;
    m = modelEval(rd_, wr_, f3, a, sd, regw, rdata);
    ex_valid = 1'b1; ex_mem_read = rd_; ex_mem_write = wr_; ex_funct3 = f3;
    ex_alu_result = a; ex_store_data = sd; ex_rd = rd; ex_reg_write = regw;
    nbusy = 0; timed_out = 1'b0; reset_hit = 1'b0;
    if (m.access) begin
      if (lat >= 0 && lat < TO) nbusy = lat + 1;
      else begin nbusy = TO; timed_out = 1'b1; end
      if (rst_at >= 0 && rst_at < nbusy) begin nbusy = rst_at + 1; reset_hit = 1'b1; end
      exp_addr = m.addr; exp_we = m.we; exp_wdata = m.wdata; exp_wstrb = m.wstrb;
      busy_lo = k + 1; busy_hi = k + nbusy;
    end
    if (!reset_hit) begin
      e.cyc = k + nbusy + 1; e.rd = rd;
      if (timed_out) begin
        e.data = 32'd0; e.regw = 1'b0; e.fault = 1'b1; e.cause = 2'b11;
      end else begin
        e.data = m.data; e.regw = m.regw; e.fault = m.fault; e.cause = m.cause;
      end
      e.chk_rd = !e.fault && !m.we;
      expq.push_back(e);
    end
    if (b2b) begin
      e.cyc = k + nbusy + 2; e.data = 32'h0000_55AA; e.regw = 1'b1; e.fault = 1'b0;
      e.cause = 2'b00; e.chk_rd = 1'b1; e.rd = 5'd7;
      expq.push_back(e);
    end
    @(posedge clk); #1;
    if (b2b) begin
      ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_funct3 = 3'd0;
      ex_alu_result = 32'h0000_55AA; ex_rd = 5'd7; ex_reg_write = 1'b1; ex_valid = 1'b1;
    end else ex_valid = 1'b0;
    for (int i = 0; i < nbusy; i++) begin
      if (i == rst_at) rst = 1'b1;
      bus.dmem_ready = (i == lat);
      bus.dmem_rdata = (i == lat) ? rdata : 32'h5A5A_A5A5;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.dmem_ready = 1'b0;
    end
    if (b2b) begin
      @(posedge clk); #1;
      ex_valid = 1'b0;
    end
    bus.dmem_ready = 1'b1;
    bus.dmem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus.dmem_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  // Model pins, reset state, then the directed instruction list.
  initial begin
    mres_t m;
    rst = 1'b1; ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_funct3 = 3'd0;
    ex_alu_result = '0; ex_store_data = '0; ex_rd = '0; ex_reg_write = 1'b0;
    bus.dmem_ready = 1'b0; bus.dmem_rdata = '0;

    m = modelEval(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1'b1, 32'h80FF_0000);
    checkOutput("pin_lb_data", m.data, 32'hFFFF_FF80);
    checkOutput("pin_lb_addr", m.addr, 32'h0000_0100);
    m = modelEval(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1'b1, 32'h80FF_0000);
    checkOutput("pin_lbu_data", m.data, 32'h0000_0080);
    m = modelEval(1'b0, 1'b1, 3'b001, 32'h202, 32'hDEAD_BEEF, 1'b0, 32'h0);
    checkOutput("pin_sh_wdata", m.wdata, 32'hBEEF_BEEF);
    checkOutput("pin_sh_wstrb", 32'(m.wstrb), 32'h0000_000C);
    m = modelEval(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 1'b1, 32'h0);
    checkOutput("pin_lw_misaligned", 32'(m.cause), 32'd1);
    m = modelEval(1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 1'b1, 32'h0);
    checkOutput("pin_rw_illegal", 32'(m.cause), 32'd2);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
    checkOutput("rst_mem_stall", 32'(mem_stall), 32'd0);
    checkOutput("rst_wb_data", wb_data, 32'd0);
    checkOutput("rst_fault", 32'({mem_fault, fault_cause}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    //              rd    wr    f3      addr          sdata          rd    rw   lat ready-data     rst  b2b
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0,         5'd5, 1'b1, -1, 32'h0,         -1, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,         5'd6, 1'b1,  0, 32'h80FF_0000, -1, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,         5'd6, 1'b1,  0, 32'h80FF_0000, -1, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 5'd3, 1'b1,  2, 32'h0,         -1, 1'b1);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,         5'd8, 1'b1,  0, 32'h0,         -1, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0,         5'd8, 1'b1,  0, 32'h0,         -1, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'b011, 32'h0000_0100, 32'h1,         5'd8, 1'b0,  0, 32'h0,         -1, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b110, 32'h0000_0100, 32'h0,         5'd8, 1'b1,  0, 32'h0,         -1, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h0000_0203, 32'h1234,      5'd8, 1'b0,  0, 32'h0,         -1, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,         5'd9, 1'b1,  1, 32'h8001_7FFF, -1, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,         5'd9, 1'b1,  0, 32'h8001_7FFF, -1, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0,         5'd10, 1'b1, 0, 32'h1234_5678, -1, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'h0000_00AB, 5'd11, 1'b0, 0, 32'h0,         -1, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b100, 32'h0000_0003, 32'h0,         5'd12, 1'b1, 3, 32'hAA00_0000, -1, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0,         5'd13, 1'b1, -1, 32'h0,        -1, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0,         5'd14, 1'b1, -1, 32'h0,         1, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 5'd15, 1'b0, 0, 32'h0,         -1, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h0000_0000, 32'h0,         5'd1, 1'b0,  0, 32'h0000_007F, -1, 1'b0);

    @(negedge clk);
    checkOutput("retire_queue_empty", 32'(expq.size()), 32'd0);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
